// File: rtl/clock_modulator_multi.sv
// Multi-channel divided-clock / tick generator with glitch-free half-period reload.
// Optional PHASE_SYNC_EN adds a phase_sync input that realigns every channel.
module clock_modulator_multi #(
  parameter int CNT_W        = 5,
  parameter int NUM_CH       = 4,
  parameter int CH_W         = 2,
  parameter int DEFAULT_HALF = 15
) (
  input  logic              clk,
  input  logic              reset,
`ifdef PHASE_SYNC_EN
  input  logic              phase_sync,
`endif
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              cfg_valid,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_half,
  output logic              cfg_ready,
  output logic [NUM_CH-1:0] usr_clk,
  output logic [NUM_CH-1:0] tick
);

  logic              sync;
  logic [NUM_CH-1:0] pend;

`ifdef PHASE_SYNC_EN
  assign sync = phase_sync;
`else
  assign sync = 1'b0;
`endif

  // Out-of-range channel numbers never match, so they stay ready.
  always_comb begin
    cfg_ready = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg_ch == CH_W'(i) && pend[i]) cfg_ready = 1'b0;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    localparam logic [CH_W-1:0] ID = CH_W'(i);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] half;
    logic [CNT_W-1:0] nxt_half;
    logic             pend_q;
    logic             usr_q;
    logic             tick_q;
    logic             wr;
    logic             term;

    assign wr   = cfg_valid && cfg_ready && (cfg_ch == ID);
    assign term = (cnt == half);

    assign pend[i]    = pend_q;
    assign usr_clk[i] = usr_q;
    assign tick[i]    = tick_q;

    // A write needs pend_q==0, so it never collides with the apply below.
    always_ff @(posedge clk) begin
      if (!reset) begin
        cnt      <= '0;
        half     <= CNT_W'(DEFAULT_HALF);
        nxt_half <= '0;
        pend_q   <= 1'b0;
        usr_q    <= 1'b0;
        tick_q   <= 1'b0;
      end else begin
        if (wr) begin
          nxt_half <= cfg_half;
          pend_q   <= 1'b1;
        end
        if (sync || !ch_en[i]) begin
          cnt    <= '0;
          usr_q  <= 1'b0;
          tick_q <= 1'b0;
          if (pend_q) begin
            half   <= nxt_half;
            pend_q <= 1'b0;
          end
        end else if (term) begin
          cnt    <= '0;
          usr_q  <= ~usr_q;
          tick_q <= 1'b1;
          if (pend_q) begin
            half   <= nxt_half;
            pend_q <= 1'b0;
          end
        end else begin
          cnt    <= cnt + CNT_W'(1);
          tick_q <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_clock_modulator_multi.sv
// Directed vector bench for clock_modulator_multi (4-channel and 3-channel builds).
module tb_clock_modulator_multi;

  typedef struct {
    logic       rst;
    logic [3:0] en;
    logic       v;
    logic [1:0] ch;
    logic [4:0] half;
    int         cyc;
    logic       rdy;
    logic [3:0] usr;
    logic [3:0] tck;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       phase_sync;
  logic [3:0] ch_en;
  logic       cfg_valid;
  logic [1:0] cfg_ch;
  logic [4:0] cfg_half;
  logic       cfg_ready;
  logic [3:0] usr_clk;
  logic [3:0] tick;

  logic [2:0] en3;
  logic       cfg3_valid;
  logic [1:0] cfg3_ch;
  logic [4:0] cfg3_half;
  logic       ready3;
  logic [2:0] usr3;
  logic [2:0] tick3;

  int nvec = 0;
  int nerr = 0;
  vec_t tbl [33];

  always #5 clk = ~clk;

  clock_modulator_multi dut (
    .clk       (clk),
    .reset     (reset),
`ifdef PHASE_SYNC_EN
    .phase_sync(phase_sync),
`endif
    .ch_en     (ch_en),
    .cfg_valid (cfg_valid),
    .cfg_ch    (cfg_ch),
    .cfg_half  (cfg_half),
    .cfg_ready (cfg_ready),
    .usr_clk   (usr_clk),
    .tick      (tick)
  );

  clock_modulator_multi #(.NUM_CH(3)) dut3 (
    .clk       (clk),
    .reset     (reset),
`ifdef PHASE_SYNC_EN
    .phase_sync(1'b0),
`endif
    .ch_en     (en3),
    .cfg_valid (cfg3_valid),
    .cfg_ch    (cfg3_ch),
    .cfg_half  (cfg3_half),
    .cfg_ready (ready3),
    .usr_clk   (usr3),
    .tick      (tick3)
  );

  function automatic vec_t mk(logic r, logic [3:0] e, logic v,
                              logic [1:0] c, logic [4:0] h, int n,
                              logic rd, logic [3:0] u, logic [3:0] t);
    vec_t x;
    x.rst = r; x.en = e; x.v = v; x.ch = c; x.half = h;
    x.cyc = n; x.rdy = rd; x.usr = u; x.tck = t;
    return x;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic edges(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; phase_sync = 1'b0; ch_en = '0;
    cfg_valid = 1'b0; cfg_ch = '0; cfg_half = '0;
    en3 = '0; cfg3_valid = 1'b0; cfg3_ch = '0; cfg3_half = '0;

    tbl[0]  = mk(0, 4'b0000, 0, 0, 0,  2, 1, 4'b0000, 4'b0000);
    tbl[1]  = mk(1, 4'b1111, 0, 0, 0, 15, 1, 4'b0000, 4'b0000);
    tbl[2]  = mk(1, 4'b1111, 0, 0, 0,  1, 1, 4'b1111, 4'b1111);
    tbl[3]  = mk(1, 4'b1111, 0, 0, 0,  1, 1, 4'b1111, 4'b0000);
    tbl[4]  = mk(1, 4'b1111, 0, 0, 0, 14, 1, 4'b1111, 4'b0000);
    tbl[5]  = mk(1, 4'b1111, 0, 0, 0,  1, 1, 4'b0000, 4'b1111);
    tbl[6]  = mk(1, 4'b1111, 0, 0, 0,  1, 1, 4'b0000, 4'b0000);
    tbl[7]  = mk(1, 4'b1111, 0, 0, 0,  4, 1, 4'b0000, 4'b0000);
    tbl[8]  = mk(1, 4'b1111, 1, 1, 3,  1, 0, 4'b0000, 4'b0000);
    tbl[9]  = mk(1, 4'b1111, 0, 1, 0,  9, 0, 4'b0000, 4'b0000);
    tbl[10] = mk(1, 4'b1111, 0, 1, 0,  1, 1, 4'b1111, 4'b1111);
    tbl[11] = mk(1, 4'b1111, 0, 1, 0,  3, 1, 4'b1111, 4'b0000);
    tbl[12] = mk(1, 4'b1111, 0, 1, 0,  1, 1, 4'b1101, 4'b0010);
    tbl[13] = mk(1, 4'b1111, 0, 1, 0,  4, 1, 4'b1111, 4'b0010);
    tbl[14] = mk(1, 4'b1111, 0, 1, 0,  4, 1, 4'b1101, 4'b0010);
    tbl[15] = mk(1, 4'b1111, 0, 1, 0,  4, 1, 4'b0010, 4'b1111);
    tbl[16] = mk(1, 4'b1111, 1, 3, 7,  1, 0, 4'b0010, 4'b0000);
    tbl[17] = mk(1, 4'b1111, 1, 3, 1,  1, 0, 4'b0010, 4'b0000);
    tbl[18] = mk(1, 4'b1111, 0, 3, 0, 14, 1, 4'b1111, 4'b1111);
    tbl[19] = mk(1, 4'b1111, 0, 3, 0,  8, 1, 4'b0111, 4'b1010);
    tbl[20] = mk(1, 4'b1111, 0, 3, 0,  8, 1, 4'b1010, 4'b1111);
    tbl[21] = mk(1, 4'b0011, 1, 2, 0,  1, 0, 4'b0010, 4'b0000);
    tbl[22] = mk(1, 4'b0011, 0, 2, 0,  1, 1, 4'b0010, 4'b0000);
    tbl[23] = mk(1, 4'b1111, 0, 2, 0,  1, 1, 4'b0110, 4'b0100);
    tbl[24] = mk(1, 4'b1111, 0, 2, 0,  1, 1, 4'b0000, 4'b0110);
    tbl[25] = mk(1, 4'b1111, 0, 2, 0,  1, 1, 4'b0100, 4'b0100);
    tbl[26] = mk(1, 4'b1111, 1, 0, 9,  1, 0, 4'b0000, 4'b0100);
    tbl[27] = mk(0, 4'b1111, 0, 0, 0,  1, 1, 4'b0000, 4'b0000);
    tbl[28] = mk(0, 4'b1111, 0, 1, 0,  0, 1, 4'b0000, 4'b0000);
    tbl[29] = mk(0, 4'b1111, 0, 2, 0,  0, 1, 4'b0000, 4'b0000);
    tbl[30] = mk(0, 4'b1111, 0, 3, 0,  0, 1, 4'b0000, 4'b0000);
    tbl[31] = mk(1, 4'b1111, 0, 0, 0, 15, 1, 4'b0000, 4'b0000);
    tbl[32] = mk(1, 4'b1111, 0, 0, 0,  1, 1, 4'b1111, 4'b1111);

    foreach (tbl[k]) begin
      reset = tbl[k].rst; ch_en = tbl[k].en; cfg_valid = tbl[k].v;
      cfg_ch = tbl[k].ch; cfg_half = tbl[k].half;
      edges(tbl[k].cyc);
      chk($sformatf("v%0d ready", k), 32'(cfg_ready), 32'(tbl[k].rdy));
      chk($sformatf("v%0d usr", k), 32'(usr_clk), 32'(tbl[k].usr));
      chk($sformatf("v%0d tick", k), 32'(tick), 32'(tbl[k].tck));
    end

    // Three-channel build: writes to channel 3 are dropped.
    reset = 1'b0; cfg_valid = 1'b0;
    edges(1);
    cfg3_ch = 2'd3;
    #1;
    chk("n3 rst ready", 32'(ready3), 32'd1);
    chk("n3 rst usr", 32'(usr3), 32'd0);
    reset = 1'b1; en3 = 3'b111;
    cfg3_valid = 1'b1; cfg3_half = 5'd0;
    edges(1);
    chk("n3 oob ready", 32'(ready3), 32'd1);
    cfg3_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      cfg3_ch = 2'(c);
      #1;
      chk($sformatf("n3 ch%0d ready", c), 32'(ready3), 32'd1);
    end
    edges(14);
    chk("n3 e15 usr", 32'(usr3), 32'd0);
    edges(1);
    chk("n3 e16 usr", 32'(usr3), 32'b111);
    chk("n3 e16 tick", 32'(tick3), 32'b111);

`ifdef PHASE_SYNC_EN
    reset = 1'b0; ch_en = 4'b0000;
    edges(1);
    reset = 1'b1; cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_half = 5'd3;
    edges(1);
    cfg_ch = 2'd1; cfg_half = 5'd7;
    edges(1);
    cfg_valid = 1'b0;
    edges(1);
    ch_en = 4'b0001;
    edges(3);
    ch_en = 4'b0011;
    edges(2);
    chk("ps offset", 32'(usr_clk[1:0]), 32'b01);
    phase_sync = 1'b1;
    edges(1);
    chk("ps sync usr", 32'(usr_clk[1:0]), 32'b00);
    chk("ps sync tick", 32'(tick[1:0]), 32'b00);
    phase_sync = 1'b0;
    edges(3);
    chk("ps +3 usr", 32'(usr_clk[1:0]), 32'b00);
    edges(1);
    chk("ps +4 usr", 32'(usr_clk[1:0]), 32'b01);
    chk("ps +4 tick", 32'(tick[1:0]), 32'b01);
    edges(3);
    chk("ps +7 usr", 32'(usr_clk[1:0]), 32'b01);
    edges(1);
    chk("ps +8 usr", 32'(usr_clk[1:0]), 32'b10);
    chk("ps +8 tick", 32'(tick[1:0]), 32'b11);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/clock_modulator_multi.md
Name: clock_modulator_multi

Overview:
- Parametrised multi-channel clock-enable / divided-clock generator; successor to the fixed single-channel divide-by-32 modulator.
- Each of NUM_CH channels produces a toggling divided clock (usr_clk) and a one-cycle tick pulse at a runtime-programmable half-period.
- Feeds display scan, debounce and game-timing logic from the single board clock.

Parameters:
- CNT_W, 5, width of each channel's counter and half-period value.
- NUM_CH, 4, number of independent channels.
- CH_W, 2, width of the cfg_ch select; must satisfy 2**CH_W >= NUM_CH.
- DEFAULT_HALF, 15, half-period loaded into every channel at reset (15 gives divide-by-32).

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-low reset: when 0 at a rising edge of clk, block resets.
- ch_en  in  NUM_CH  per-channel run enable.
- cfg_valid  in  1  configuration write request.
- cfg_ch  in  CH_W  target channel of the write.
- cfg_half  in  CNT_W  new half-period value.
- cfg_ready  out  1  write may be accepted this cycle (combinational from pending state and cfg_ch).
- usr_clk  out  NUM_CH  divided clock per channel (registered).
- tick  out  NUM_CH  one-cycle pulse per channel, coincident with each usr_clk edge (registered).

Behaviour:
- Reset (reset==0 at a clk edge): all counters 0, usr_clk 0, tick 0, half regs = DEFAULT_HALF, pending flags cleared. Reset overrides every other input, including mid-period and mid-write.
- Per channel, enabled: counter increments by 1 each cycle. In a cycle where counter==half, next edge sets counter to 0, toggles usr_clk and sets tick to 1. Otherwise tick is 0. Period = 2*(half+1) cycles, duty 50%.
- half==0: usr_clk toggles every cycle (divide-by-2), tick constantly 1.
- Counter width CNT_W: counter never exceeds half, so no wrap occurs.
- ch_en low: next edge forces counter 0, usr_clk 0, tick 0; held while low. Re-enable: counting restarts from 0, first toggle (to 1) appears half+1 cycles after ch_en rises.
- Config handshake:
  - Write accepted when cfg_valid && cfg_ready.
  - cfg_ready = !pending[cfg_ch]; it is 1 whenever cfg_ch >= NUM_CH.
  - An accepted write to a valid channel stores cfg_half in that channel's pending register and sets its pending flag on the next edge.
  - An accepted write to cfg_ch >= NUM_CH is silently dropped.
- Apply rule (glitch-free):
  - A set pending value is copied into half on the edge that ends a terminal-count cycle (counter==half with pending already set). Pending clears on that same edge. The new period starts with the following count.
  - If the channel is disabled while pending is set, the value applies on the next edge.
  - A write accepted in the same cycle as a terminal count does not apply at that terminal count. It applies at the next one.
- Channels are fully independent. Simultaneous writes are impossible (one cfg port), and each channel's terminal counts are handled independently.

Optional Feature:
- Macro: PHASE_SYNC_EN.
- Defined: adds input port phase_sync (1 bit).
  - When phase_sync==1 at an edge, every channel immediately applies any pending half (clearing pending) and sets counter 0, usr_clk 0, tick 0.
  - Enabled channels then resume counting, aligning all channel phases.
  - reset has priority over phase_sync; phase_sync has priority over terminal count and over ch_en-low handling (result identical).
- Not defined: port absent; channels are never re-aligned except by reset or ch_en.

Test Plan:
- Reset then ch_en=4'b1111, no writes -> each usr_clk rises 16 cycles after enable, period 32 cycles. tick is high for exactly 1 cycle every 16 cycles.
- Channel 1 running half=15; write cfg_half=3 at counter=5 -> cfg_ready[ch1] low until applied. Current half-period completes at 16 cycles, then period 8 cycles. No runt pulse.
- Write cfg_half=0 to channel 2 while ch_en[2]=0, then enable -> pending applied next edge. After enable, usr_clk[2] toggles every cycle and tick[2] stays 1.
- Write with cfg_ch=3 while channel 3 has a pending value -> cfg_ready=0, write not accepted. Write to cfg_ch beyond NUM_CH (NUM_CH=3 build) -> cfg_ready=1, no channel changes.
- Assert reset=0 mid-period with a pending write -> next edge: all usr_clk/tick 0, half=15, pending cleared. cfg_ready=1 for all channels.
- (PHASE_SYNC_EN) channels at halves 3 and 7, offset phases; pulse phase_sync -> both usr_clk 0 next cycle. They rise together 4 and 8 cycles later respectively.
